// File: rtl/arith_pkg.sv
// Shared types and helpers for the bit-serial arithmetic library.
package arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } serial_state_t;

    // Bit counter must be able to hold the value WIDTH itself without wrapping.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/full_adder_cell.sv
// One-bit full adder; the only arithmetic element of the serial datapaths.
module full_adder_cell (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = x ^ y ^ ci;
    assign co = (x & y) | (ci & (x ^ y));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: LSB-first through one full-adder cell, with a
// start/busy/done handshake and registered sum/cout that update only on completion.
module serial_adder
    import arith_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    serial_state_t    state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;

    logic fa_s;
    logic fa_co;

    full_adder_cell u_fa (
        .x  (a_q[0]),
        .y  (b_q[0]),
        .ci (carry_q),
        .s  (fa_s),
        .co (fa_co)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        shift_d = shift_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        sum_d   = sum_q;
        cout_d  = cout_q;

        unique case (state_q)
            IDLE, DONE: begin
                // DONE accepts a new start directly so back-to-back ops skip IDLE.
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    shift_d = '0;
                    busy_d  = 1'b1;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                shift_d = {fa_s, shift_q[WIDTH-1:1]};
                carry_d = fa_co;
                cnt_d   = cnt_q + CW'(1);
                // Last bit: publish the result including the bit computed this cycle.
                if (cnt_q == LAST_BIT) begin
                    sum_d   = {fa_s, shift_q[WIDTH-1:1]};
                    cout_d  = fa_co;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = DONE;
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            shift_q <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            shift_q <= shift_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed plus random bench for serial_adder at WIDTH=8 and WIDTH=16, with a
// scoreboard queue per instance checked on every done pulse.
module tb_serial_adder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start8, start16;
    logic        cin8, cin16;
    logic [7:0]  a8, b8, sum8;
    logic [15:0] a16, b16, sum16;
    logic        busy8, done8, cout8;
    logic        busy16, done16, cout16;

    int n_vec = 0;
    int n_bad = 0;
    int acc8 = 0, acc16 = 0;
    int done_cnt8 = 0, done_cnt16 = 0;
    logic [7:0]  last8  = '0;
    logic [15:0] last16 = '0;
    logic [16:0] sb8[$];
    logic [16:0] sb16[$];

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );

    serial_adder #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .a(a16), .b(b16), .cin(cin16),
        .busy(busy16), .done(done16), .sum(sum16), .cout(cout16)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard monitors: compare on done, otherwise sum must hold the last result.
    always @(negedge clk) begin
        logic [16:0] e;
        if (!rst_n) begin
            last8 = '0;
        end else if (done8) begin
            done_cnt8++;
            if (sb8.size() == 0) begin
                n_vec++;
                n_bad++;
                $error("FAIL unexpected_done8: observed done=1 expected no pending op");
            end else begin
                e = sb8.pop_front();
                chk("result8", 32'({cout8, sum8}), 32'(e[8:0]));
                last8 = e[7:0];
            end
        end else begin
            chk("hold8", 32'(sum8), 32'(last8));
        end
    end

    always @(negedge clk) begin
        logic [16:0] e;
        if (!rst_n) begin
            last16 = '0;
        end else if (done16) begin
            done_cnt16++;
            if (sb16.size() == 0) begin
                n_vec++;
                n_bad++;
                $error("FAIL unexpected_done16: observed done=1 expected no pending op");
            end else begin
                e = sb16.pop_front();
                chk("result16", 32'({cout16, sum16}), 32'(e));
                last16 = e[15:0];
            end
        end else begin
            chk("hold16", 32'(sum16), 32'(last16));
        end
    end

    // Drive an accepted start for the coming edge and record its expected result.
    task automatic drive(input int w, input logic [15:0] a, input logic [15:0] b, input logic ci);
        logic [16:0] e;
        if (w == 8) begin
            a8 = a[7:0]; b8 = b[7:0]; cin8 = ci; start8 = 1'b1;
            e = 17'(a[7:0]) + 17'(b[7:0]) + 17'(ci);
            sb8.push_back(e);
            acc8++;
        end else begin
            a16 = a; b16 = b; cin16 = ci; start16 = 1'b1;
            e = 17'(a) + 17'(b) + 17'(ci);
            sb16.push_back(e);
            acc16++;
        end
    endtask

    // Wait (bounded) for done; operands are scrambled meanwhile since they are don't-care.
    task automatic wait_done(input int w, output int cyc);
        cyc = 0;
        while (!((w == 8) ? done8 : done16) && cyc < 60) begin
            if (w == 8) begin
                a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
            end else begin
                a16 = 16'($urandom); b16 = 16'($urandom); cin16 = 1'($urandom);
            end
            @(negedge clk);
            cyc++;
        end
        if (!((w == 8) ? done8 : done16)) begin
            n_vec++;
            n_bad++;
            $error("FAIL timeout_w%0d: observed no done after %0d cycles expected done", w, cyc);
        end
    endtask

    task automatic run_op(input int w, input logic [15:0] a, input logic [15:0] b, input logic ci);
        int c;
        drive(w, a, b, ci);
        @(negedge clk);
        if (w == 8) start8 = 1'b0; else start16 = 1'b0;
        wait_done(w, c);
        @(negedge clk);
    endtask

    initial begin
        int c, c2, d0;
        rst_n = 1'b0;
        start8 = 1'b0; start16 = 1'b0;
        a8 = '0; b8 = '0; cin8 = 1'b0;
        a16 = '0; b16 = '0; cin16 = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_busy8", 32'(busy8), 32'd0);
        chk("rst_done8", 32'(done8), 32'd0);
        chk("rst_sum8", 32'(sum8), 32'd0);
        chk("rst_cout8", 32'(cout8), 32'd0);
        chk("rst_busy16", 32'(busy16), 32'd0);
        chk("rst_sum16", 32'(sum16), 32'd0);
        #2 rst_n = 1'b1;
        @(negedge clk);

        // Test 1: handshake timing for 0x35 + 0x4A
        drive(8, 16'h35, 16'h4A, 1'b0);
        @(negedge clk);
        start8 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("t1_busy_%0d", i), 32'(busy8), 32'd1);
            chk($sformatf("t1_done_%0d", i), 32'(done8), 32'd0);
            @(negedge clk);
        end
        chk("t1_busy_end", 32'(busy8), 32'd0);
        chk("t1_done_end", 32'(done8), 32'd1);
        @(negedge clk);
        chk("t1_done_pulse", 32'(done8), 32'd0);

        // Test 2: carry boundaries
        run_op(8, 16'hFF, 16'h01, 1'b0);
        run_op(8, 16'hFF, 16'hFF, 1'b1);
        run_op(8, 16'h00, 16'h00, 1'b1);

        // Test 3: start while busy is ignored
        d0 = done_cnt8;
        drive(8, 16'h10, 16'h20, 1'b0);
        @(negedge clk);
        start8 = 1'b0;
        repeat (2) @(negedge clk);
        a8 = 8'hAA; b8 = 8'h55; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        wait_done(8, c);
        repeat (3) @(negedge clk);
        #1 chk("t3_one_done", 32'(done_cnt8 - d0), 32'd1);

        // Test 4: back-to-back accept in the DONE cycle
        @(negedge clk);
        drive(8, 16'h0F, 16'h01, 1'b0);
        @(negedge clk);
        start8 = 1'b0;
        wait_done(8, c);
        drive(8, 16'h80, 16'h80, 1'b0);
        @(negedge clk);
        start8 = 1'b0;
        chk("t4_busy_no_idle", 32'(busy8), 32'd1);
        wait_done(8, c2);
        chk("t4_gap", 32'(1 + c2), 32'd9);
        @(negedge clk);

        // Test 5: asynchronous reset mid-RUN
        drive(8, 16'hC3, 16'h3C, 1'b0);
        @(negedge clk);
        start8 = 1'b0;
        repeat (4) @(negedge clk);
        d0 = done_cnt8;
        #2 rst_n = 1'b0;
        #1;
        chk("t5_busy", 32'(busy8), 32'd0);
        chk("t5_done", 32'(done8), 32'd0);
        chk("t5_sum", 32'(sum8), 32'd0);
        chk("t5_cout", 32'(cout8), 32'd0);
        sb8.delete();
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (12) @(negedge clk);
        #1 chk("t5_no_done", 32'(done_cnt8 - d0), 32'd0);
        @(negedge clk);
        run_op(8, 16'h01, 16'h01, 1'b0);

        // Test 6: random sweeps at both widths
        for (int i = 0; i < 1000; i++)
            run_op(8, 16'($urandom), 16'($urandom), 1'($urandom));
        for (int i = 0; i < 1000; i++)
            run_op(16, 16'($urandom), 16'($urandom), 1'($urandom));

        @(negedge clk);
        #1;
        chk("done_vs_accept8", 32'(done_cnt8), 32'(acc8 - 1));
        chk("done_vs_accept16", 32'(done_cnt16), 32'(acc16));
        chk("sb8_empty", 32'(sb8.size()), 32'd0);
        chk("sb16_empty", 32'(sb16.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
Bit-serial N-bit adder; the additive counterpart of the team's subtractor datapath. It adds two latched operands plus a carry-in, LSB first, one bit per clock, through a single full-adder cell. It sits beside the subtractor in the arithmetic library and replaces a wide ripple adder where area matters more than latency. A start/busy/done handshake sequences each operation.

Parameters:
WIDTH, 8, operand and result width in bits (legal range 2..32).

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  asynchronous active-low reset.
start  input  1  request a new addition; sampled on clk rising edge.
a  input  WIDTH  operand A; sampled only when start is accepted.
b  input  WIDTH  operand B; sampled only when start is accepted.
cin  input  1  carry-in; sampled only when start is accepted.
busy  output  1  high while an addition is in progress.
done  output  1  one-cycle pulse when sum and cout become valid.
sum  output  WIDTH  registered result; holds the last completed value.
cout  output  1  registered carry-out; holds the last completed value.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE.
  - busy = 0, done = 0, sum = 0, cout = 0.
  - Internal operand, shift, carry and count registers cleared.
- States: IDLE, RUN, DONE.
- IDLE:
  - start = 1 at edge k latches a, b and cin into internal registers, sets count = 0, goes to RUN.
  - busy = 1 from edge k.
- RUN, one bit per cycle:
  - bit = a_reg[0] + b_reg[0] + carry_reg, computed by full_adder_cell.
  - Sum bit shifts into the MSB of an internal shift register (right shift).
  - a_reg and b_reg shift right by one; carry_reg takes the cell's carry-out; count increments.
- Completion:
  - RUN ends on the edge where count reaches WIDTH, i.e. edge k+WIDTH.
  - On that edge: sum and cout are loaded from the shift register and carry_reg, state goes to DONE, busy drops to 0, done goes to 1.
- DONE lasts exactly one cycle:
  - done = 1 for that cycle only.
  - Next state is IDLE, or RUN if start = 1 in that cycle (back-to-back accept, same latch actions as IDLE).
- Latency: start accepted at edge k gives done high between edges k+WIDTH and k+WIDTH+1. Throughput is one result per WIDTH+1 cycles.
- start while busy = 1 is ignored. No queueing; operands in flight are unaffected.
- sum and cout change only on the completion edge (and on reset). They never show partial results during RUN.
- Arithmetic: {cout, sum} = a + b + cin, modulo 2^(WIDTH+1). Unsigned; no overflow flag.
- Reset asserted mid-operation aborts it immediately:
  - All outputs return to reset values.
  - No done pulse is produced for the aborted operation.
- The counter is $clog2(WIDTH+1) bits wide; it must not wrap before reaching WIDTH.
- a, b and cin may change freely except on the accepting edge.

Decomposition:
- Shared package arith_pkg:
  - state enum serial_state_t {IDLE, RUN, DONE}.
  - Function cnt_width(WIDTH) returning $clog2(WIDTH+1).
- One sub-module, full_adder_cell:
  - Combinational; inputs x, y, ci; outputs s, co.
  - Reused by a future serial subtractor with b inverted and borrow mapping.
- FSM, counter and shift registers live in serial_adder.

Test Plan:
1. Reset release, then start with a=0x35, b=0x4A, cin=0 at edge k -> busy=1 for edges k..k+7, done pulses once after edge k+8, sum=0x7F, cout=0.
2. a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. Then a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1. Then a=0x00, b=0x00, cin=1 -> sum=0x01, cout=0.
3. Start 0x10+0x20; pulse start with a=0xAA, b=0x55 at edge k+3 -> ignored; result sum=0x30, cout=0, exactly one done pulse.
4. Start 0x0F+0x01; assert start with 0x80+0x80 during the DONE cycle -> first done gives 0x10, cout=0; second operation accepted with no IDLE cycle, done 9 cycles after the first, sum=0x00, cout=1.
5. Start 0xC3+0x3C, assert rst_n=0 mid-RUN (between edges k+4 and k+5, asynchronously) -> busy, done, sum and cout all 0 immediately, no done pulse. After release, 0x01+0x01 gives sum=0x02.
6. Randomised sweep of 1000 operands at WIDTH=8 and WIDTH=16 against the reference model a+b+cin -> every result matches, done count equals accepted-start count, and sum is stable between done pulses.
